// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: command/response bundle between the SPI slave front end and the RAM controller.
interface spi_ram_ctrl_if;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       seq_err;
    logic       parity_err;
    modport master (output rx_data, rx_valid, input tx_data, tx_valid, seq_err, parity_err);
    modport slave  (input rx_data, rx_valid, output tx_data, tx_valid, seq_err, parity_err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: byte RAM driven by 10-bit SPI command words, one command per rx_valid rising edge.
// Optional macro SPI_RAM_PARITY_EN adds an even-parity bit per location and the parity_err flag.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input logic          clk,
    input logic          rst_n,
    spi_ram_ctrl_if.slave bus
);
    localparam logic IDLE    = 1'b0;
    localparam logic TX_HOLD = 1'b1;
`ifdef SPI_RAM_PARITY_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif
    logic                 rv_q, state, wr_ok, rd_ok, cmd_stb, do_wr, do_rd;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic [1:0]           op;
    logic [7:0]           pay;
    logic [W-1:0]         mem [MEM_DEPTH];
    logic [W-1:0]         wr_word, rd_word;
    assign op      = bus.rx_data[9:8];
    assign pay     = bus.rx_data[7:0];
    assign cmd_stb = bus.rx_valid & ~rv_q;
    assign do_wr   = cmd_stb & (op == 2'b01) & wr_ok;
    assign do_rd   = cmd_stb & (op == 2'b11) & rd_ok;
    assign rd_word = mem[rd_addr];
    assign bus.tx_valid = state;
`ifdef SPI_RAM_PARITY_EN
    assign wr_word = {^pay, pay};
`else
    assign wr_word = pay;
`endif
    // Memory is never reset; the rst_n gate drops a command that coincides with reset.
    always_ff @(posedge clk)
        if (rst_n && do_wr) mem[wr_addr] <= wr_word;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv_q        <= 1'b1;
            state       <= IDLE;
            wr_ok       <= 1'b0;
            rd_ok       <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            bus.tx_data <= '0;
            bus.seq_err <= 1'b0;
        end else begin
            rv_q        <= bus.rx_valid;
            bus.seq_err <= cmd_stb & op[0] & ~(op[1] ? rd_ok : wr_ok);
            state       <= do_rd ? TX_HOLD : (cmd_stb ? IDLE : state);
            if (cmd_stb && op == 2'b00) begin
                wr_addr <= pay[ADDR_SIZE-1:0];
                wr_ok   <= 1'b1;
            end
            if (cmd_stb && op == 2'b10) begin
                rd_addr <= pay[ADDR_SIZE-1:0];
                rd_ok   <= 1'b1;
            end
            if (do_wr) wr_addr <= wr_addr + 1'b1;
            if (do_rd) begin
                rd_addr     <= rd_addr + 1'b1;
                bus.tx_data <= rd_word[7:0];
            end
        end
    end
`ifdef SPI_RAM_PARITY_EN
    always_ff @(posedge clk)
        if (!rst_n) bus.parity_err <= 1'b0;
        else bus.parity_err <= do_rd ? (rd_word[8] != ^rd_word[7:0]) : (cmd_stb ? 1'b0 : bus.parity_err);
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: random command stream checked against a byte-array reference model.
module tb_spi_ram_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    logic [7:0] mem_m [256];
    logic       corrupt [256];
    int   wa, ra;
    logic wok, rok, txv, serr, perr;
    logic [7:0] txd;

    spi_ram_ctrl_if bus ();
    spi_ram_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".tx_data"}, int'(bus.tx_data), int'(txd));
        chk({tag, ".tx_valid"}, int'(bus.tx_valid), int'(txv));
        chk({tag, ".seq_err"}, int'(bus.seq_err), int'(serr));
        chk({tag, ".parity_err"}, int'(bus.parity_err), int'(perr));
    endtask

    task automatic model(input logic [9:0] w);
        logic [7:0] p;
        p = w[7:0];
        serr = 1'b0;
        perr = 1'b0;
        case (w[9:8])
            2'd0: begin wa = p; wok = 1'b1; txv = 1'b0; end
            2'd1: begin
                if (wok) begin mem_m[wa] = p; corrupt[wa] = 1'b0; wa = (wa + 1) % 256; end
                else serr = 1'b1;
                txv = 1'b0;
            end
            2'd2: begin ra = p; rok = 1'b1; txv = 1'b0; end
            default: begin
                if (rok) begin
                    txd = mem_m[ra];
                    txv = 1'b1;
`ifdef SPI_RAM_PARITY_EN
                    perr = corrupt[ra];
`endif
                    ra = (ra + 1) % 256;
                end else begin
                    serr = 1'b1;
                    txv = 1'b0;
                end
            end
        endcase
    endtask

    // Called on a falling edge with rx_valid low for at least one preceding rising edge.
    task automatic send(input logic [9:0] w, input int hold);
        bus.rx_data = w;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        model(w);
        @(negedge clk);
        check_outs("cmd");
        serr = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check_outs("hold");
        end
        bus.rx_valid = 1'b0;
        bus.rx_data = 10'($urandom);
        @(negedge clk);
        check_outs("idle");
    endtask

    task automatic do_reset(input logic v, input logic [9:0] d);
        rst_n = 1'b0;
        bus.rx_valid = v;
        bus.rx_data = d;
        wa = 0; ra = 0; wok = 1'b0; rok = 1'b0;
        txd = 8'h00; txv = 1'b0; serr = 1'b0; perr = 1'b0;
        @(negedge clk);
        check_outs("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs("rst_rel");
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check_outs("rst_idle");
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;
        @(negedge clk);
        do_reset(1'b1, 10'h3_00);
        send(10'h3_00, 1);
        send(10'h1_77, 2);
        send(10'h0_00, 1);
        for (int i = 0; i < 256; i++) send({2'b01, 8'($urandom)}, 1);
        send(10'h0_05, 1);
        send(10'h1_A5, 1);
        send(10'h2_05, 1);
        send(10'h3_00, 3);
        send(10'h0_00, 1);
        send(10'h1_3C, 20);
        send(10'h2_00, 1);
        send(10'h3_00, 1);
        send(10'h3_00, 1);
        send(10'h0_FF, 1);
        send(10'h1_11, 1);
        send(10'h1_22, 1);
        send(10'h2_FF, 1);
        send(10'h3_00, 1);
        send(10'h3_00, 1);
        send(10'h0_00, 1);
        send(10'h2_40, 1);
        send(10'h0_40, 1);
        send(10'h3_00, 1);
        send(10'h1_99, 1);
        send(10'h0_0A, 1);
        do_reset(1'b1, 10'h1_EE);
        send(10'h2_0A, 1);
        send(10'h3_00, 1);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset(1'($urandom), 10'($urandom));
            else send(10'($urandom), $urandom_range(1, 4));
        end
        send(10'h0_03, 1);
        send(10'h1_0F, 1);
`ifdef SPI_RAM_PARITY_EN
        dut.mem[3][8] = ~dut.mem[3][8];
        corrupt[3] = 1'b1;
`endif
        send(10'h2_03, 1);
        send(10'h3_00, 2);
        send(10'h2_00, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
